gpio_sw_debounce: RTL and testbench
===================================

// Module: gpio_sw_debounce
// PURPOSE
//  Synchronises and debounces the board slide switches before they reach the
//  SoC GPIO inputs (gpio_in[15:0]); sits between the sw pins and pulpino_top.
//  Per channel: 2-FF synchroniser, stability counter, registered clean level,
//  one-cycle rise/fall pulses and a sticky change flag software can poll/clear.
// PARAMETERS
//  N_CH             16       number of switch channels
//  DEBOUNCE_CYCLES  100000   consecutive stable cycles required to accept a level (>=1)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  per-channel counter width (derived)
// PORTS
//  clk        in   1      system clock (MMCM output)
//  rst        in   1      synchronous reset, active-high
//  sw_i       in   N_CH   raw asynchronous switch pins
//  clr_i      in   1      clears changed_o (single-cycle pulse)
//  sw_o       out  N_CH   debounced level -> gpio_in[N_CH-1:0]
//  rise_o     out  N_CH   1-cycle pulse: channel accepted 0->1
//  fall_o     out  N_CH   1-cycle pulse: channel accepted 1->0
//  changed_o  out  1      sticky: any accepted edge since last clr_i/reset
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): sync stages s1/s2, sw_o, counters, rise_o,
//    fall_o, changed_o all 0. rst mid-count discards all progress.
//  - Sync: s1<=sw_i, s2<=s1 every edge; only s2 is used downstream.
//  - Per channel i, every edge:
//    * s2[i]==sw_o[i]: cnt[i]<=0.
//    * s2[i]!=sw_o[i] and cnt[i]<DEBOUNCE_CYCLES-1: cnt[i]<=cnt[i]+1.
//    * s2[i]!=sw_o[i] and cnt[i]==DEBOUNCE_CYCLES-1: sw_o[i]<=s2[i], cnt[i]<=0,
//      rise_o[i] (if s2=1) or fall_o[i] (if s2=0) asserted for exactly that next cycle.
//  - Latency: pin change first sampled by s1 at edge 0 -> s2 at edge 1 ->
//    sw_o updates at edge DEBOUNCE_CYCLES+1 (DEBOUNCE_CYCLES=1: edge 2).
//  - Glitch: any single cycle with s2==sw_o restarts count from 0; a pulse
//    shorter than DEBOUNCE_CYCLES cycles at s2 never reaches sw_o.
//  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.
//  - Channels independent; several may update on the same edge (multiple
//    rise_o/fall_o bits set together).
//  - changed_o: set on edge where any channel updates; cleared by clr_i;
//    set and clr_i on same edge -> set wins (changed_o=1).
//  - Switch already high at reset release: seen as a change; sw_o rises with
//    rise_o pulse DEBOUNCE_CYCLES+1 edges after reset deasserts.
//  - All outputs registered; no combinational path sw_i/clr_i -> outputs.
// TESTING (bench uses DEBOUNCE_CYCLES=4, N_CH=16)
//  1 rst held 3 cycles, sw_i=0 -> all outputs 0; remain 0 for 20 cycles.
//  2 sw_i[3] 0->1 held -> sw_o[3]=1 at edge 5 after first sampling edge,
//    rise_o[3]=1 for one cycle, changed_o=1 and stays 1.
//  3 sw_i[7] high for 3 cycles then low -> sw_o[7], rise_o[7], changed_o stay 0.
//  4 sw_i=16'hFFFF from reset release -> sw_o=16'hFFFF and rise_o=16'hFFFF
//    same cycle; then sw_i=0 -> fall_o=16'hFFFF one cycle, sw_o=0.
//  5 clr_i pulse with no edge -> changed_o 1->0; clr_i on same edge as an
//    accepted edge -> changed_o remains 1.
//  6 rst asserted with cnt[2]=3 mid-debounce -> sw_o[2]=0, no pulse; after
//    release full DEBOUNCE_CYCLES+1 edges required again.

Source files
------------

// File: rtl/gpio_sw_debounce_if.sv
// Switch-debounce signal bundle: raw pins and clear in, clean levels and edge
// indications out.
interface gpio_sw_debounce_if #(
    parameter int N_CH = 16
);
    logic [N_CH-1:0] sw_i;
    logic            clr_i;
    logic [N_CH-1:0] sw_o;
    logic [N_CH-1:0] rise_o;
    logic [N_CH-1:0] fall_o;
    logic            changed_o;

    modport master (
        output sw_i,
        output clr_i,
        input  sw_o,
        input  rise_o,
        input  fall_o,
        input  changed_o
    );

    modport slave (
        input  sw_i,
        input  clr_i,
        output sw_o,
        output rise_o,
        output fall_o,
        output changed_o
    );
endinterface

// File: rtl/gpio_sw_debounce.sv
// Per-channel synchroniser and stability-counter debouncer for the board slide
// switches, with one-cycle rise/fall pulses and a sticky software change flag.
module gpio_sw_debounce #(
    parameter  int N_CH            = 16,
    parameter  int DEBOUNCE_CYCLES = 100000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    gpio_sw_debounce_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  sync1;
    logic [N_CH-1:0]  sync2;
    logic [N_CH-1:0]  level;
    logic [N_CH-1:0]  rise;
    logic [N_CH-1:0]  fall;
    logic [N_CH-1:0]  accept;
    logic             changed;
    logic [CNT_W-1:0] cnt [N_CH];

    // A channel accepts its new level once it has disagreed for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CH; i++) begin
            accept[i] = (sync2[i] != level[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= bus.sw_i;
            sync2 <= sync1;
            level <= level ^ accept;
            rise  <= accept & sync2;
            fall  <= accept & ~sync2;
            for (int i = 0; i < N_CH; i++) begin
                if ((sync2[i] == level[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
            // A fresh acceptance outranks a simultaneous software clear.
            if (|accept) begin
                changed <= 1'b1;
            end else if (bus.clr_i) begin
                changed <= 1'b0;
            end
        end
    end

    assign bus.sw_o      = level;
    assign bus.rise_o    = rise;
    assign bus.fall_o    = fall;
    assign bus.changed_o = changed;

endmodule

// File: tb/tb_gpio_sw_debounce.sv
// Self-checking bench for gpio_sw_debounce: directed vector table, hand-written
// corner sequences and randomized stimulus against a sliding-window model.
module tb_gpio_sw_debounce;

    localparam int N_CH  = 16;
    localparam int DC    = 4;
    localparam int MAX_E = 2048;

    typedef struct {
        logic [15:0] sw;
        logic        clr;
        logic        rst;
        logic [15:0] exp_sw;
        logic [15:0] exp_rise;
        logic [15:0] exp_fall;
        logic        exp_changed;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    gpio_sw_debounce_if #(.N_CH(N_CH)) bus ();

    gpio_sw_debounce #(
        .N_CH            (N_CH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference: a channel flips when its synchronised input (pins delayed two
    // edges) has differed from the accepted level on each of the last DC edges,
    // all of them after the most recent reset release and acceptance.
    logic [15:0] hist [MAX_E];
    int          edge_no  = 0;
    int          rel_edge = 0;
    int          last_flip [N_CH];
    logic [15:0] m_level   = '0;
    logic [15:0] m_rise    = '0;
    logic [15:0] m_fall    = '0;
    logic        m_changed = 1'b0;

    function automatic logic [15:0] seen_at(int k);
        if (k - 2 >= rel_edge && k >= 2) return hist[k-2];
        return 16'h0000;
    endfunction

    task automatic model_step(input logic [15:0] sw, input logic clr, input logic r);
        logic [15:0] seen;
        logic        ok;
        int          e;
        hist[edge_no] = sw;
        if (r) begin
            m_level   = '0;
            m_rise    = '0;
            m_fall    = '0;
            m_changed = 1'b0;
            rel_edge  = edge_no + 1;
            for (int c = 0; c < N_CH; c++) last_flip[c] = edge_no;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N_CH; c++) begin
                ok = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    e    = edge_no - j;
                    seen = seen_at(e);
                    if (e < rel_edge || e <= last_flip[c] || seen[c] == m_level[c]) ok = 1'b0;
                end
                if (ok) begin
                    m_level[c]   = ~m_level[c];
                    m_rise[c]    = m_level[c];
                    m_fall[c]    = ~m_level[c];
                    last_flip[c] = edge_no;
                end
            end
            if ((m_rise | m_fall) != 16'h0000) m_changed = 1'b1;
            else if (clr)                      m_changed = 1'b0;
        end
        edge_no++;
    endtask

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with the model advanced.
    task automatic apply_stimulus(input logic [15:0] sw, input logic clr, input logic r);
        bus.sw_i  = sw;
        bus.clr_i = clr;
        rst       = r;
        @(posedge clk);
        model_step(sw, clr, r);
        @(negedge clk);
    endtask

    task automatic check_output(input string tag);
        compare({tag, " sw_o"},      bus.sw_o,   m_level);
        compare({tag, " rise_o"},    bus.rise_o, m_rise);
        compare({tag, " fall_o"},    bus.fall_o, m_fall);
        compare({tag, " changed_o"}, {15'h0, bus.changed_o}, {15'h0, m_changed});
    endtask

    task automatic check_const(input string tag, input logic [15:0] s, input logic [15:0] ri,
                               input logic [15:0] fa, input logic ch);
        compare({tag, " sw_o const"},      bus.sw_o,   s);
        compare({tag, " rise_o const"},    bus.rise_o, ri);
        compare({tag, " fall_o const"},    bus.fall_o, fa);
        compare({tag, " changed_o const"}, {15'h0, bus.changed_o}, {15'h0, ch});
    endtask

    vec_t vecs[$];

    function automatic void add_vec(input logic [15:0] sw, input logic clr, input logic r,
                                    input logic [15:0] es, input logic [15:0] er,
                                    input logic [15:0] ef, input logic ec);
        vec_t v;
        v.sw = sw; v.clr = clr; v.rst = r;
        v.exp_sw = es; v.exp_rise = er; v.exp_fall = ef; v.exp_changed = ec;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [15:0] cur;
        logic [15:0] mask;

        for (int c = 0; c < N_CH; c++) last_flip[c] = -1;
        bus.sw_i  = '0;
        bus.clr_i = 1'b0;
        rst       = 1'b1;
        @(negedge clk);

        // Reset, idle, single-channel rise, short glitch, software clear.
        for (int i = 0; i < 3; i++)  add_vec(16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 20; i++) add_vec(16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++)  add_vec(16'h0008, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        add_vec(16'h0008, 1'b0, 1'b0, 16'h0008, 16'h0008, 16'h0000, 1'b1);
        for (int i = 0; i < 2; i++)  add_vec(16'h0008, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++)  add_vec(16'h0088, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 6; i++)  add_vec(16'h0008, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b1);
        add_vec(16'h0008, 1'b1, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0);
        add_vec(16'h0008, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 1'b0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].sw, vecs[i].clr, vecs[i].rst);
            check_const($sformatf("vec%0d", i), vecs[i].exp_sw, vecs[i].exp_rise,
                        vecs[i].exp_fall, vecs[i].exp_changed);
            check_output($sformatf("vec%0d model", i));
        end

        // All channels high from reset release, then all low.
        for (int i = 0; i < 3; i++) apply_stimulus(16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(16'hFFFF, 1'b0, 1'b0);
            check_output("allhi wait");
        end
        check_const("allhi before", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        apply_stimulus(16'hFFFF, 1'b0, 1'b0);
        check_const("allhi accept", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1);
        apply_stimulus(16'hFFFF, 1'b0, 1'b0);
        check_const("allhi pulse end", 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) apply_stimulus(16'h0000, 1'b0, 1'b0);
        check_const("alllo before", 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
        apply_stimulus(16'h0000, 1'b0, 1'b0);
        check_const("alllo accept", 16'h0000, 16'h0000, 16'hFFFF, 1'b1);

        // Clear with no edge, then clear coinciding with an acceptance.
        apply_stimulus(16'h0000, 1'b1, 1'b0);
        check_const("clr idle", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) apply_stimulus(16'h0001, 1'b0, 1'b0);
        apply_stimulus(16'h0001, 1'b1, 1'b0);
        check_const("clr vs edge", 16'h0001, 16'h0001, 16'h0000, 1'b1);

        // Reset in the middle of a debounce discards progress.
        for (int i = 0; i < 2; i++) apply_stimulus(16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) apply_stimulus(16'h0004, 1'b0, 1'b0);
        apply_stimulus(16'h0004, 1'b0, 1'b1);
        check_const("rst midcount", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(16'h0004, 1'b0, 1'b0);
            check_output("post rst wait");
        end
        check_const("post rst before", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        apply_stimulus(16'h0004, 1'b0, 1'b0);
        check_const("post rst accept", 16'h0004, 16'h0004, 16'h0000, 1'b1);

        // Random toggling: mix of glitches and held levels, occasional clear/reset.
        cur = 16'h0004;
        for (int n = 0; n < 500; n++) begin
            mask = '0;
            for (int b = 0; b < N_CH; b++) mask[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) mask = 16'hFFFF;
            cur = cur ^ mask;
            apply_stimulus(cur, ($urandom_range(0, 9) == 0), ($urandom_range(0, 149) == 0));
            check_output("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
